// File: rtl/fir_result_display.sv
// FIFO-buffered stream sink: shows the selected byte of each accepted
// sample on two active-low seven-segment digits for a fixed hold time.
module fir_result_display #(
   parameter int DATA_WIDTH  = 16,
   parameter int FIFO_DEPTH  = 4,
   parameter int HOLD_CYCLES = 50_000_000,
   parameter int BYTE_SEL    = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  enable,
   input  logic                  rIn1,
   input  logic [DATA_WIDTH-1:0] dataIn1,
   output logic                  rdy,
   output logic                  LEDG,
   output logic [6:0]            HEX0,
   output logic [6:0]            HEX1
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
   localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_HOLD
   } state_t;

   state_t state;
   state_t state_nx;

   logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]         wr_ptr;
   logic [AW-1:0]         rd_ptr;
   logic [CW-1:0]         count;
   logic [HW-1:0]         hold_cnt;
   logic [7:0]            disp;
   logic                  shown;
   logic                  ledg_q;

   logic                  full;
   logic                  empty;
   logic                  pop;
   logic                  push;
   logic                  ovf;
   logic                  load_hold;
   logic                  dec_hold;
   logic [DATA_WIDTH-1:0] head;
   logic                  unused_head;

   assign full  = (count == FULL_CNT);
   assign empty = (count == '0);
   assign head  = mem[rd_ptr];
   assign unused_head = ^head;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next-state logic; a low enable freezes the state
   always_comb begin
      state_nx = state;
      if (enable) begin
         unique case (state)
            S_IDLE: if (!empty) state_nx = S_LOAD;
            S_LOAD: state_nx = S_HOLD;
            S_HOLD: begin
               if (hold_cnt == '0) begin
                  state_nx = empty ? S_IDLE : S_LOAD;
               end
            end
            default: state_nx = S_IDLE;
         endcase
      end
   end

   // FSM outputs
   always_comb begin
      pop       = 1'b0;
      load_hold = 1'b0;
      dec_hold  = 1'b0;
      if (enable) begin
         unique case (state)
            S_LOAD: begin
               pop       = 1'b1;
               load_hold = 1'b1;
            end
            S_HOLD:  dec_hold = (hold_cnt != '0);
            default: ;
         endcase
      end
   end

   // A pop in the same cycle frees a slot for the incoming sample
   assign push = enable & rIn1 & (~full | pop);
   assign ovf  = enable & rIn1 & full & ~pop;

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= dataIn1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         hold_cnt <= '0;
         disp     <= '0;
         shown    <= 1'b0;
         ledg_q   <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (ovf) ledg_q <= 1'b1;
         if (load_hold) begin
            hold_cnt <= HOLD_LOAD;
         end else if (dec_hold) begin
            hold_cnt <= hold_cnt - 1'b1;
         end
         if (pop) begin
            disp  <= head[8*BYTE_SEL +: 8];
            shown <= 1'b1;
         end
      end
   end

   function automatic logic [6:0] seg7(input logic [3:0] n);
      logic [6:0] s;
      unique case (n)
         4'h0: s = 7'b1000000;
         4'h1: s = 7'b1111001;
         4'h2: s = 7'b0100100;
         4'h3: s = 7'b0110000;
         4'h4: s = 7'b0011001;
         4'h5: s = 7'b0010010;
         4'h6: s = 7'b0000010;
         4'h7: s = 7'b1111000;
         4'h8: s = 7'b0000000;
         4'h9: s = 7'b0010000;
         4'hA: s = 7'b0001000;
         4'hB: s = 7'b0000011;
         4'hC: s = 7'b1000110;
         4'hD: s = 7'b0100001;
         4'hE: s = 7'b0000110;
         4'hF: s = 7'b0001110;
      endcase
      return s;
   endfunction

   assign rdy  = ~full;
   assign LEDG = ledg_q;
   assign HEX0 = shown ? seg7(disp[3:0]) : 7'b1111111;
   assign HEX1 = shown ? seg7(disp[7:4]) : 7'b1111111;

endmodule

// File: doc/fir_result_display.md
# fir_result_display

Stream sink at the output end of the FIR datapath. It accepts 16-bit filtered samples on a valid-strobe interface, which is the same `rIn`/`dataIn` convention the counter source uses into the filter. Accepted samples are buffered in a small FIFO. Each sample is then shown on two active-low seven-segment digits for a fixed hold period. A sticky overflow indicator drives `LEDG`.

## Interface
- `DATA_WIDTH`, 16: sample width.
- `FIFO_DEPTH`, 4: buffer entries; power of two, at least 2.
- `HOLD_CYCLES`, 50_000_000: clock cycles each sample stays in HOLD; at least 1.
- `BYTE_SEL`, 0: byte shown on the digits; 0 = `dataIn1[7:0]`, 1 = `dataIn1[15:8]`.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `enable`  in  1  global run enable; when low, all state holds.
- `rIn1`  in  1  sample-valid strobe from the filter.
- `dataIn1`  in  DATA_WIDTH  sample, qualified by `rIn1`.
- `rdy`  out  1  FIFO not full: `count != FIFO_DEPTH`, decoded from registers only.
- `LEDG`  out  1  sticky overflow flag.
- `HEX0`  out  7  low nibble of the displayed byte, active-low, bit0=a … bit6=g.
- `HEX1`  out  7  high nibble of the displayed byte, same encoding.

## Operation
FIFO:
- Circular buffer with read/write pointers and a count register of log2(FIFO_DEPTH)+1 bits.
- Pointers wrap modulo FIFO_DEPTH.
- Push condition: `enable & rIn1 & (count != FIFO_DEPTH | pop)`. A push and a pop in the same cycle while full are both accepted, and count is unchanged.
- Overflow: `enable & rIn1 & full & !pop` drops the sample and sets `LEDG`. `LEDG` clears only on reset.

FSM has three states:
- IDLE: goes to LOAD when the FIFO is not empty.
- LOAD: pops the head entry, latches the selected byte into the display register, loads the hold counter with HOLD_CYCLES-1, then goes to HOLD.
- HOLD: decrements the hold counter. At counter = 0, goes to LOAD if the FIFO is not empty, otherwise to IDLE.
- Entering IDLE does not change the display; the last byte stays shown.

Display:
- Registered display byte plus a `shown` flag. The flag is set on the first LOAD after reset.
- While `shown` is 0, HEX0 and HEX1 are blank (7'b1111111).
- Hex encoding:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- Segment decode is combinational from the display register, so HEX outputs have no extra latency.

Enable:
- `enable` low freezes FSM state, hold counter, FIFO contents and pointers.
- `rIn1` is ignored while `enable` is low: no push and no overflow.

Reset (`rst` asserted, asynchronously, at any time, including mid-HOLD):
- State = IDLE; count, pointers and hold counter = 0.
- Display register = 0, `shown` = 0.
- `LEDG` = 0, HEX0 = HEX1 = 7'b1111111, `rdy` = 1.

## Timing
- Push at edge N into an empty FIFO while IDLE: state = LOAD after edge N+1; display updated after edge N+2.
- A new sample therefore reaches the digits 2 cycles after acceptance.
- Steady-state display period with a non-empty FIFO: HOLD_CYCLES+1 cycles per sample (one LOAD cycle plus HOLD_CYCLES in HOLD).
- `rdy` reflects count after each edge and is valid throughout the following cycle.
- `LEDG` rises on the edge that drops a sample.
- A pop in LOAD frees a slot visible to the same edge's push decision; no bubble when full.
- Sustained input faster than 1 sample per HOLD_CYCLES+1 cycles overflows by design. The filter side may watch `rdy`, but is not required to.

## Test plan
All scenarios use HOLD_CYCLES=4, FIFO_DEPTH=4, BYTE_SEL=0.
- **Reset values:** assert `rst` mid-cycle with no clock edge → immediately `LEDG`=0, `rdy`=1, HEX0 = HEX1 = 1111111.
- **Single sample:** `dataIn1` = 16'h12A5 strobed for 1 cycle at edge N → after edge N+2, HEX1=0001000 ('A') and HEX0=0010010 ('5'). State returns to IDLE after 4 HOLD cycles and the display still shows A5.
- **Back-to-back burst:** 4 samples 0x0001..0x0004 on consecutive cycles → `rdy`=0 only after the 4th push if no pop has occurred yet. The display steps 01, 02, 03, 04, each change 5 cycles apart. `LEDG` stays 0.
- **Overflow:** 6 consecutive samples 0x10..0x15 → 0x15 is dropped and `LEDG`=1 from that edge on. The display sequence is 10, 11, 12, 13, 14. `LEDG` stays 1 until `rst`.
- **Simultaneous push/pop at full:** FIFO full, strobe `rIn1` on the LOAD cycle → sample accepted, count stays 4, `LEDG` stays 0.
- **Enable freeze and reset mid-HOLD:** drop `enable` mid-HOLD for 10 cycles → display, counter and FIFO frozen, and a strobe during the freeze is ignored. Then assert `rst` mid-HOLD → all outputs return to their reset values with no clock edge.
